// File: rtl/ultrasonic_scan_ctrl.sv
// rtl/ultrasonic_scan_ctrl.sv - round-robin multi-channel ultrasonic ranging controller
// Triggers each sensor in turn, times its echo and latches a per-channel distance in cm.
module ultrasonic_scan_ctrl #(
  parameter int NUM_CH       = 3,
  parameter int DIST_W       = 9,
  parameter int TRIG_CYCLES  = 1000,
  parameter int CM_CYCLES    = 5800,
  parameter int ECHO_TIMEOUT = 3000000,
  parameter int GAP_CYCLES   = 6000000,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLK_EN,
  input  logic [NUM_CH-1:0]        ECHO_I,
  output logic [NUM_CH-1:0]        TRIG_O,
  output logic [NUM_CH*DIST_W-1:0] DIST_O,
  output logic                     VALID_O,
  output logic [CH_W-1:0]          CH_O,
  output logic                     TIMEOUT_O
);

  localparam int CNT_MAX = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TCNT_W  = $clog2(ECHO_TIMEOUT + 1);
  localparam int DIV_W   = $clog2(CM_CYCLES + 1);
  localparam logic [DIST_W-1:0] CM_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_GAP
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_CH-1:0]         sync1_q, sync2_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [TCNT_W-1:0]         tcnt_q, tcnt_d;
  logic [DIV_W-1:0]          div_q, div_d, div_nxt;
  logic [DIST_W-1:0]         cm_q, cm_d, cm_nxt;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [NUM_CH-1:0]         trig_q, trig_d;
  logic [NUM_CH*DIST_W-1:0]  dist_q, dist_d;
  logic                      valid_q, valid_d;
  logic [CH_W-1:0]           ch_out_q, ch_out_d;
  logic                      timeout_q, timeout_d;
  logic                      echo_s;
  logic                      store, store_to;

  assign echo_s = sync2_q[ch_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    div_d     = div_q;
    cm_d      = cm_q;
    ch_d      = ch_q;
    trig_d    = trig_q;
    dist_d    = dist_q;
    valid_d   = 1'b0;
    ch_out_d  = ch_out_q;
    timeout_d = timeout_q;
    store     = 1'b0;
    store_to  = 1'b0;

    div_nxt = div_q + 1'b1;
    cm_nxt  = cm_q;
    if (div_q == DIV_W'(CM_CYCLES - 1)) begin
      div_nxt = '0;
      if (cm_q != CM_MAX) cm_nxt = cm_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (CLK_EN) begin
          state_d = S_TRIG;
          cnt_d   = '0;
          trig_d  = NUM_CH'(1) << ch_q;
        end
      end
      S_TRIG: begin
        if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
          state_d = S_WAIT_RISE;
          trig_d  = '0;
          tcnt_d  = '0;
          div_d   = '0;
          cm_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_RISE: begin
        if (echo_s) begin
          state_d = S_MEASURE;
          tcnt_d  = tcnt_q + 1'b1;
          div_d   = div_nxt;
          cm_d    = cm_nxt;
        end else if (tcnt_q >= TCNT_W'(ECHO_TIMEOUT - 1)) begin
          store    = 1'b1;
          store_to = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_MEASURE: begin
        // Falling echo is checked first so it wins over a coincident timeout
        if (!echo_s) begin
          store = 1'b1;
        end else if (tcnt_q >= TCNT_W'(ECHO_TIMEOUT - 1)) begin
          store    = 1'b1;
          store_to = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          div_d  = div_nxt;
          cm_d   = cm_nxt;
        end
      end
      S_GAP: begin
        if (cnt_q >= CNT_W'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
          ch_d    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Gap counter starts at 1 so the IDLE cycle completes the GAP_CYCLES spacing
    if (store) begin
      state_d   = S_GAP;
      cnt_d     = CNT_W'(1);
      valid_d   = 1'b1;
      ch_out_d  = ch_q;
      timeout_d = store_to;
      dist_d[int'(ch_q)*DIST_W +: DIST_W] = store_to ? CM_MAX : cm_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      div_q     <= '0;
      cm_q      <= '0;
      ch_q      <= '0;
      trig_q    <= '0;
      dist_q    <= '0;
      valid_q   <= 1'b0;
      ch_out_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= ECHO_I;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      div_q     <= div_d;
      cm_q      <= cm_d;
      ch_q      <= ch_d;
      trig_q    <= trig_d;
      dist_q    <= dist_d;
      valid_q   <= valid_d;
      ch_out_q  <= ch_out_d;
      timeout_q <= timeout_d;
    end
  end

  assign TRIG_O    = trig_q;
  assign DIST_O    = dist_q;
  assign VALID_O   = valid_q;
  assign CH_O      = ch_out_q;
  assign TIMEOUT_O = timeout_q;

endmodule

// File: doc/ultrasonic_scan_ctrl.md
Name: ultrasonic_scan_ctrl

Overview:
Multi-channel ultrasonic ranging controller. It is the parametrised successor to the single-channel trigger generator. Round-robin over NUM_CH sensors, it:
- fires a trigger pulse of configurable width,
- measures the echo pulse width,
- converts the width to centimetres,
- reports a per-channel distance with a valid strobe and a timeout flag.

It sits between the sensor I/O pins and the obstacle-avoidance logic.

Parameters:
NUM_CH, 3, number of sensor channels (1..8)
DIST_W, 9, distance result width in cm; saturation value is 2^DIST_W-1
TRIG_CYCLES, 1000, trigger high time in CLK cycles (10 us at 100 MHz)
CM_CYCLES, 5800, echo-high CLK cycles per 1 cm (58 us at 100 MHz)
ECHO_TIMEOUT, 3000000, max cycles from end of trigger to echo fall (30 ms)
GAP_CYCLES, 6000000, idle cycles after each measurement before next channel (60 ms)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
CLK_EN  in  1  scan enable; gates only the start of a new trigger
ECHO_I  in  NUM_CH  asynchronous echo inputs, one per sensor
TRIG_O  out  NUM_CH  trigger outputs, at most one bit high at a time
DIST_O  out  NUM_CH*DIST_W  per-channel latched distance in cm; channel k occupies bits [k*DIST_W +: DIST_W]
VALID_O  out  1  one-cycle strobe when a result is stored
CH_O  out  clog2(NUM_CH) (min 1)  channel index of the current/last result
TIMEOUT_O  out  1  high with VALID_O when the stored result was a timeout

Behaviour:
Reset and synchronisation:
- Reset (RST=1 at a CLK edge) applies to every register: TRIG_O=0, DIST_O=0, VALID_O=0, CH_O=0, TIMEOUT_O=0, state=IDLE, current channel ch=0, all counters=0.
- RST asserted in any state aborts the operation: TRIG_O drops on the next edge and no result is stored.
- Each ECHO_I bit passes through a 2-flop synchroniser. All echo decisions use the synchronised bit of the current channel, echo_s = sync(ECHO_I[ch]).

State machine (IDLE, TRIG, WAIT_RISE, MEASURE, GAP):
- IDLE: if CLK_EN=1, go to TRIG with the cycle counter cleared. Otherwise stay in IDLE.
- TRIG: TRIG_O[ch]=1, registered, for exactly TRIG_CYCLES consecutive cycles. Then TRIG_O=0 and go to WAIT_RISE. The timeout counter tcnt and the cm/div counters are cleared on this transition.
- WAIT_RISE: tcnt increments every cycle.
  - echo_s=1 -> go to MEASURE. This first high cycle counts as a measured cycle.
  - tcnt reaches ECHO_TIMEOUT-1 with no rise -> store a timeout result.
- MEASURE: tcnt keeps incrementing. While echo_s=1:
  - div increments each cycle;
  - when div==CM_CYCLES-1, div resets to 0 and cm increments;
  - cm saturates at 2^DIST_W-1 and never wraps.
  - echo_s=0 -> store cm as a normal result.
  - tcnt reaches ECHO_TIMEOUT-1 -> store a timeout result.
  - If the echo fall and the timeout occur in the same cycle, the echo fall wins (normal result).
- Store (one cycle, entering GAP):
  - DIST_O slice for ch is updated; other slices are unchanged.
  - CH_O=ch and VALID_O=1 for one cycle.
  - Normal result: TIMEOUT_O=0, value = cm.
  - Timeout result: TIMEOUT_O=1, value = 2^DIST_W-1.
  - TIMEOUT_O holds until the next store.
- GAP: wait GAP_CYCLES cycles. Then ch = (ch==NUM_CH-1) ? 0 : ch+1 and go to IDLE.

CLK_EN and timing rules:
- CLK_EN low while in TRIG, WAIT_RISE, MEASURE or GAP does not abort; the in-flight cycle completes through GAP, then waits in IDLE.
- Echo edges on non-selected channels are ignored.
- Latency: the echo fall on the pin reaches VALID_O 3 cycles later (2 synchroniser cycles + 1 store cycle).
- Distance = floor(synchronised echo-high cycles / CM_CYCLES), saturated.
- Counter widths: each counter must hold its maximum parameter value without overflow.

Test Plan:
Bench parameters: NUM_CH=2, DIST_W=5, TRIG_CYCLES=10, CM_CYCLES=4, ECHO_TIMEOUT=200, GAP_CYCLES=20.
1. Reset: assert RST 3 cycles with ECHO_I=2'b11 -> all outputs 0. After release with CLK_EN=0, TRIG_O stays 0 for 100 cycles.
2. Basic: CLK_EN=1; drive ECHO_I[0] high for 40 cycles starting 5 cycles after TRIG_O[0] falls -> TRIG_O[0] high exactly 10 cycles; VALID_O single pulse 3 cycles after the pin fall; CH_O=0; DIST_O[4:0]=10; TIMEOUT_O=0; DIST_O[9:5]=0.
3. Round-robin: channel 1 echo of 22 cycles, then channel 0 again -> TRIG_O[1] rises 20 cycles after the first VALID_O, DIST_O[9:5]=5 with CH_O=1, next trigger on TRIG_O[0]; TRIG_O never 2'b11.
4. No echo: ECHO_I=0 -> VALID_O 200 cycles after TRIG_O falls, DIST=31, TIMEOUT_O=1. Then a 40-cycle echo -> TIMEOUT_O=0, DIST=10.
5. Saturation and wrong-channel: echo high 150 cycles on ch0 (fall before timeout) -> DIST=31, TIMEOUT_O=0. Toggling ECHO_I[1] during ch0 measurement -> no effect on the result.
6. Abort and hold: RST mid-MEASURE -> TRIG_O=0, no VALID_O, ch restarts at 0, DIST_O=0. CLK_EN dropped mid-MEASURE -> result still stored, no further TRIG_O until CLK_EN=1.
